// File: rtl/mdu_sched_if.sv
// mdu_sched_if - E-stage <-> multiply/divide unit connection.
//
// Signals:
//   start  : MDU-class instruction valid in E this cycle
//   op     : operation code (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//            5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE)
//   rs/rt  : forwarded operands
//   cancel : exception/interrupt flush this cycle
//   busy   : a mult/div is in flight (stall request)
//   hi/lo  : architectural HI/LO
//   rdata  : combinational MFHI/MFLO read data
//
// master = E stage side, slave = MDU side.
interface mdu_sched_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, hi, lo, rdata
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, hi, lo, rdata
  );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched - sequencer for the shared multiply/divide resource in E.
//
// Accepts one HI/LO-class operation per cycle, latches its operands, counts
// out a fixed latency and then commits the full result to HI/LO in a single
// edge, so HI/LO never show partial results. MTHI/MTLO write in one cycle,
// MFHI/MFLO are served combinationally on rdata.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : mdu_sched_if.slave (start/op/rs/rt/cancel in; busy/hi/lo/rdata out)
//
// Parameters:
//   MUL_CYCLES : busy cycles for mult/multu (1..15)
//   DIV_CYCLES : busy cycles for div/divu  (1..15)
//
// Optional feature macro: MDU_FAST_ZERO_EN
//   When defined, a MULT/MULTU with a zero operand completes after one busy
//   cycle. Divides are unaffected.
module mdu_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_sched_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  logic [0:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic [3:0]  op_reg;
  logic [31:0] rs_reg;
  logic [31:0] rt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy_reg;

  logic        op_valid;
  logic        acc;
  logic        zero_mul;

  // Ops 1..8 are real operations; everything else is a no-op.
  assign op_valid = (bus.op >= OP_MULT) && (bus.op <= OP_MTLO);
  assign acc      = bus.start & ~bus.cancel & ~busy_reg & op_valid;

`ifdef MDU_FAST_ZERO_EN
  assign zero_mul = (bus.rs == 32'd0) || (bus.rt == 32'd0);
`else
  assign zero_mul = 1'b0;
`endif

  // ---------------- result datapath (from latched operands) ----------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = {{32{rs_reg[31]}}, rs_reg} * {{32{rt_reg[31]}}, rt_reg};
  assign prod_u = {32'd0, rs_reg} * {32'd0, rt_reg};

  // Signed divide is done on magnitudes. The magnitude of 0x80000000 is
  // 0x80000000 as an unsigned value, so 0x80000000 / -1 naturally yields
  // quotient 0x80000000 and remainder 0 without a special case.
  assign div_signed = (op_reg == OP_DIV);
  assign neg_a      = div_signed & rs_reg[31];
  assign neg_b      = div_signed & rt_reg[31];
  assign mag_a      = neg_a ? (32'd0 - rs_reg) : rs_reg;
  assign mag_b      = neg_b ? (32'd0 - rt_reg) : rt_reg;
  // Divide-by-zero results are never committed; keep the divider defined.
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / mag_b_safe;
  assign r_mag      = mag_a % mag_b_safe;
  assign quot       = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
  assign rem        = neg_a ? (32'd0 - r_mag) : r_mag;

  logic        res_we;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_we = 1'b0;
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (op_reg)
      OP_MULT: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        // rt == 0: run the full latency but leave HI/LO untouched.
        if (rt_reg != 32'd0) begin
          res_we = 1'b1;
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      op_reg    <= 4'd0;
      rs_reg    <= 32'd0;
      rt_reg    <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (acc) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                op_reg    <= bus.op;
                rs_reg    <= bus.rs;
                rt_reg    <= bus.rt;
                cnt_reg   <= zero_mul ? 4'd1 : MUL_CNT;
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_reg    <= bus.op;
                rs_reg    <= bus.rs;
                rt_reg    <= bus.rt;
                cnt_reg   <= DIV_CNT;
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
              end
              OP_MTHI: hi_reg <= bus.rs;
              OP_MTLO: lo_reg <= bus.rs;
              default: ;  // MFHI/MFLO are read-only
            endcase
          end
        end
        default: begin  // ST_RUN: in-flight op always completes
          if (cnt_reg == 4'd1) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= 4'd0;
            if (res_we) begin
              hi_reg <= res_hi;
              lo_reg <= res_lo;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.rdata = 32'd0;
    if (bus.op == OP_MFHI)      bus.rdata = hi_reg;
    else if (bus.op == OP_MFLO) bus.rdata = lo_reg;
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule
